// File: rtl/hazard_sequencer_types_pkg.sv
// Shared types for the pipeline hazard sequencer: PC select codes,
// memory-wait FSM states and pipeline latch indices.
package hazard_sequencer_types_pkg;

  typedef enum logic [1:0] {
    PC_NPC = 2'd0,
    PC_BPC = 2'd1,
    PC_PTA = 2'd2,
    PC_JPC = 2'd3
  } pcsel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } hseq_state_t;

  localparam int L_IFID = 0;
  localparam int L_IDEX = 1;
  localparam int L_EXMM = 2;
  localparam int L_MMWB = 3;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the hazard
// sequencer's performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard control for a 5-stage pipeline: memory-wait sequencing, load-use
// stalls, multi-cycle execute stalls, redirects and performance counters.
//
// state | meaning
// RUN   | normal operation, no outstanding memory access
// DWAIT | data access pending, whole pipeline frozen
// IWAIT | data access done and recorded, waiting for instruction fetch
module hazard_sequencer
  import hazard_sequencer_types_pkg::*;
#(
  parameter int LU_DIST = 1,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 16,
  parameter int RADDR_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               ex_load,
  input  logic [RADDR_W-1:0] ex_wsel,
  input  logic               mm_load,
  input  logic [RADDR_W-1:0] mm_wsel,
  input  logic               mm_memop,
  input  logic               mm_br_taken,
  input  logic               ex_jr,
  input  logic               ex_jump,
  input  logic               ex_mc_start,
  output logic [1:0]         pc_sel,
  output logic               pc_en,
  output logic [3:0]         latch_en,
  output logic [3:0]         latch_flush,
  output logic               mc_busy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int MC_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 1);

  hseq_state_t     state;
  logic [MC_W-1:0] mc_cnt;
  logic            lu_ex;
  logic            lu_mm;
  logic            lu_hazard;
  logic            mem_hold;
  logic            mem_split;
  logic            redirect;

  always_comb begin
    lu_ex = ex_load && (ex_wsel != '0) &&
            ((id_use_rs && (id_rs == ex_wsel)) || (id_use_rt && (id_rt == ex_wsel)));
    lu_mm = (LU_DIST == 2) && mm_load && (mm_wsel != '0) &&
            ((id_use_rs && (id_rs == mm_wsel)) || (id_use_rt && (id_rt == mm_wsel)));
    lu_hazard = lu_ex || lu_mm;

    mem_hold  = ((state == RUN) && mm_memop && !dhit) || ((state == DWAIT) && !dhit);
    mem_split = (state == IWAIT) ||
                (dhit && !ihit && (((state == RUN) && mm_memop) || (state == DWAIT)));
    // Redirects wait out a frozen pipeline and take effect on release.
    redirect  = !mem_hold && (mm_br_taken || ex_jr || ex_jump);
  end

  always_comb begin
    pc_sel      = PC_NPC;
    pc_en       = ihit;
    latch_en    = {4{ihit}};
    latch_flush = 4'b0000;
    if (RST) begin
      pc_en       = 1'b0;
      latch_en    = 4'b0000;
      latch_flush = 4'b1111;
    end else if (mem_hold) begin
      pc_en    = 1'b0;
      latch_en = 4'b0000;
    end else begin
      if (mem_split) begin
        latch_en[L_EXMM]    = 1'b1;
        latch_en[L_MMWB]    = 1'b1;
        latch_flush[L_EXMM] = 1'b1;
      end
      if (redirect) begin
        latch_flush[L_IFID] = 1'b1;
        latch_flush[L_IDEX] = 1'b1;
        if (mm_br_taken) begin
          pc_sel              = PC_BPC;
          latch_flush[L_EXMM] = 1'b1;
        end else if (ex_jr) begin
          pc_sel = PC_PTA;
        end else begin
          pc_sel = PC_JPC;
        end
      end else if (mc_busy) begin
        pc_en               = 1'b0;
        latch_en[L_IFID]    = 1'b0;
        latch_en[L_IDEX]    = 1'b0;
        latch_en[L_EXMM]    = 1'b0;
        latch_en[L_MMWB]    = 1'b1;
        latch_flush[L_EXMM] = 1'b1;
      end else if (lu_hazard) begin
        pc_en               = 1'b0;
        latch_en[L_IFID]    = 1'b0;
        latch_flush[L_IDEX] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      mc_cnt  <= '0;
      mc_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mm_memop) begin
            if (!dhit)      state <= DWAIT;
            else if (!ihit) state <= IWAIT;
          end
        end
        DWAIT: begin
          if (dhit) state <= ihit ? RUN : IWAIT;
        end
        IWAIT: begin
          if (ihit) state <= RUN;
        end
        default: state <= RUN;
      endcase

      // mc_busy mirrors (mc_cnt != 0) so it can drive stalls glitch-free.
      if (redirect) begin
        mc_cnt  <= '0;
        mc_busy <= 1'b0;
      end else if (mc_busy) begin
        if (ihit) begin
          mc_cnt  <= mc_cnt - 1'b1;
          mc_busy <= (mc_cnt != MC_W'(1));
        end
      end else if ((state == RUN) && ex_mc_start) begin
        mc_cnt  <= MC_LOAD;
        mc_busy <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (~pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (|latch_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: two instances (LU_DIST=1/CNT_W=16 and
// LU_DIST=2/CNT_W=4) share stimulus; expectations flow through a queue.
module tb_hazard_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit;
  logic [4:0] id_rs, id_rt, ex_wsel, mm_wsel;
  logic       id_use_rs, id_use_rt, ex_load, mm_load, mm_memop;
  logic       mm_br_taken, ex_jr, ex_jump, ex_mc_start;

  logic [1:0]  a_pc_sel, b_pc_sel;
  logic        a_pc_en, b_pc_en, a_mc_busy, b_mc_busy;
  logic [3:0]  a_latch_en, b_latch_en, a_latch_flush, b_latch_flush;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  typedef struct {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] fl;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          cnt_known = 1'b0;
  logic [15:0] exp_stall_a, exp_flush_a;
  logic [3:0]  exp_stall_b, exp_flush_b;

  always #5 CLK = ~CLK;

  hazard_sequencer #(.LU_DIST(1), .MC_LAT(4), .CNT_W(16), .RADDR_W(5)) dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_load(ex_load), .ex_wsel(ex_wsel), .mm_load(mm_load), .mm_wsel(mm_wsel),
    .mm_memop(mm_memop), .mm_br_taken(mm_br_taken), .ex_jr(ex_jr), .ex_jump(ex_jump),
    .ex_mc_start(ex_mc_start), .pc_sel(a_pc_sel), .pc_en(a_pc_en),
    .latch_en(a_latch_en), .latch_flush(a_latch_flush), .mc_busy(a_mc_busy),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_sequencer #(.LU_DIST(2), .MC_LAT(4), .CNT_W(4), .RADDR_W(5)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_load(ex_load), .ex_wsel(ex_wsel), .mm_load(mm_load), .mm_wsel(mm_wsel),
    .mm_memop(mm_memop), .mm_br_taken(mm_br_taken), .ex_jr(ex_jr), .ex_jump(ex_jump),
    .ex_mc_start(ex_mc_start), .pc_sel(b_pc_sel), .pc_en(b_pc_en),
    .latch_en(b_latch_en), .latch_flush(b_latch_flush), .mc_busy(b_mc_busy),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  function automatic exp_t mk(input logic pe, input logic [3:0] en, input logic [3:0] fl,
                              input logic [1:0] sel, input logic busy);
    exp_t e;
    e.pc_en = pe; e.en = en; e.fl = fl; e.sel = sel; e.busy = busy;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b1;
    id_rs = '0; id_rt = '0; ex_wsel = '0; mm_wsel = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_load = 1'b0; mm_load = 1'b0; mm_memop = 1'b0;
    mm_br_taken = 1'b0; ex_jr = 1'b0; ex_jump = 1'b0; ex_mc_start = 1'b0;
  endtask

  // One clock: queue expectations, sample at negedge, then update counter model.
  task automatic step(input string tag, input exp_t ea, input exp_t eb);
    exp_t pa, pb;
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(negedge CLK);
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    cmp({tag, ".a.pc_en"}, 32'(a_pc_en), 32'(pa.pc_en));
    cmp({tag, ".a.en"},    32'(a_latch_en), 32'(pa.en));
    cmp({tag, ".a.fl"},    32'(a_latch_flush), 32'(pa.fl));
    cmp({tag, ".a.sel"},   32'(a_pc_sel), 32'(pa.sel));
    cmp({tag, ".b.pc_en"}, 32'(b_pc_en), 32'(pb.pc_en));
    cmp({tag, ".b.en"},    32'(b_latch_en), 32'(pb.en));
    cmp({tag, ".b.fl"},    32'(b_latch_flush), 32'(pb.fl));
    cmp({tag, ".b.sel"},   32'(b_pc_sel), 32'(pb.sel));
    if (cnt_known) begin
      cmp({tag, ".a.busy"},  32'(a_mc_busy), 32'(pa.busy));
      cmp({tag, ".b.busy"},  32'(b_mc_busy), 32'(pb.busy));
      cmp({tag, ".a.stall"}, 32'(a_stall_cnt), 32'(exp_stall_a));
      cmp({tag, ".a.flush"}, 32'(a_flush_cnt), 32'(exp_flush_a));
      cmp({tag, ".b.stall"}, 32'(b_stall_cnt), 32'(exp_stall_b));
      cmp({tag, ".b.flush"}, 32'(b_flush_cnt), 32'(exp_flush_b));
    end
    if (RST) begin
      exp_stall_a = '0; exp_flush_a = '0; exp_stall_b = '0; exp_flush_b = '0;
      cnt_known = 1'b1;
    end else begin
      if (!pa.pc_en && exp_stall_a != 16'hFFFF) exp_stall_a++;
      if ((pa.fl != 4'b0) && exp_flush_a != 16'hFFFF) exp_flush_a++;
      if (!pb.pc_en && exp_stall_b != 4'hF) exp_stall_b++;
      if ((pb.fl != 4'b0) && exp_flush_b != 4'hF) exp_flush_b++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t rst_e, nrm, hold, split, lu, busy;
    logic [15:0] flush_before;
    rst_e = mk(1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0);
    nrm   = mk(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    hold  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    split = mk(1'b0, 4'b1100, 4'b0100, 2'd0, 1'b0);
    lu    = mk(1'b0, 4'b1110, 4'b0010, 2'd0, 1'b0);
    busy  = mk(1'b0, 4'b1000, 4'b0100, 2'd0, 1'b1);
    exp_stall_a = '0; exp_flush_a = '0; exp_stall_b = '0; exp_flush_b = '0;

    idle();
    RST = 1'b1;
    step("rst0", rst_e, rst_e);
    step("rst1", rst_e, rst_e);
    RST = 1'b0;
    step("post_rst", nrm, nrm);

    // Data miss, then late instruction fetch.
    mm_memop = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) step("dwait", hold, hold);
    dhit = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 2; i++) step("iwait", split, split);
    ihit = 1'b1; mm_memop = 1'b0;
    step("iwait_rel", mk(1'b1, 4'b1111, 4'b0100, 2'd0, 1'b0), mk(1'b1, 4'b1111, 4'b0100, 2'd0, 1'b0));
    step("run_back", nrm, nrm);
    cmp("mem_stall_total", 32'(a_stall_cnt), 32'd5);

    // Load-use through EX and (LU_DIST=2 only) MM.
    ex_load = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
    step("lu_rt", lu, lu);
    ex_wsel = 5'd0; id_rt = 5'd0;
    step("lu_r0", nrm, nrm);
    ex_wsel = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b0;
    step("lu_rs", lu, lu);
    id_use_rs = 1'b0;
    step("lu_nouse", nrm, nrm);
    idle();
    mm_load = 1'b1; mm_wsel = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    step("lu_mm", nrm, lu);
    mm_wsel = 5'd0; id_rs = 5'd0;
    step("lu_mm_r0", nrm, nrm);
    idle();

    // Multi-cycle op, then one squashed by a branch.
    ex_mc_start = 1'b1;
    step("mc_start", nrm, nrm);
    ex_mc_start = 1'b0;
    for (int i = 0; i < 3; i++) step("mc_busy", busy, busy);
    step("mc_done", nrm, nrm);
    ex_mc_start = 1'b1;
    step("mc_start2", nrm, nrm);
    ex_mc_start = 1'b0;
    step("mc_busy2", busy, busy);
    mm_br_taken = 1'b1;
    step("mc_squash", mk(1'b1, 4'b1111, 4'b0111, 2'd1, 1'b1), mk(1'b1, 4'b1111, 4'b0111, 2'd1, 1'b1));
    mm_br_taken = 1'b0;
    step("mc_after_sq", nrm, nrm);

    // Redirect priority over jr and load-use.
    flush_before = a_flush_cnt;
    mm_br_taken = 1'b1; ex_jr = 1'b1;
    ex_load = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
    step("br_prio", mk(1'b1, 4'b1111, 4'b0111, 2'd1, 1'b0), mk(1'b1, 4'b1111, 4'b0111, 2'd1, 1'b0));
    cmp("br_flush_inc", 32'(a_flush_cnt - flush_before), 32'd1);
    mm_br_taken = 1'b0; ex_jump = 1'b1;
    step("jr_prio", mk(1'b1, 4'b1111, 4'b0011, 2'd2, 1'b0), mk(1'b1, 4'b1111, 4'b0011, 2'd2, 1'b0));
    idle();
    ex_jump = 1'b1;
    step("jump", mk(1'b1, 4'b1111, 4'b0011, 2'd3, 1'b0), mk(1'b1, 4'b1111, 4'b0011, 2'd3, 1'b0));
    mm_memop = 1'b1; dhit = 1'b0;
    step("jump_held", hold, hold);
    dhit = 1'b1;
    step("jump_rel", mk(1'b1, 4'b1111, 4'b0011, 2'd3, 1'b0), mk(1'b1, 4'b1111, 4'b0011, 2'd3, 1'b0));
    idle();
    step("idle", nrm, nrm);

    // Counter saturation on the 4-bit instance.
    RST = 1'b1;
    step("rst_sat", rst_e, rst_e);
    RST = 1'b0; mm_memop = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 19; i++) step("sat_hold", hold, hold);
    cmp("sat_b", 32'(b_stall_cnt), 32'hF);
    cmp("sat_a", 32'(a_stall_cnt), 32'd19);
    dhit = 1'b1; mm_memop = 1'b0;
    step("sat_rel", nrm, nrm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
